// File: rtl/ipv_group_reducer.sv
// ipv_group_reducer: reduces K-beat groups of CH indicator bits to per-channel
// ones-counts, delivered through a fixed LAT-stage delay line.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, ipv_in    beat strobe and per-channel indicator bits
//   flush               close the current group early
//   vov                 per-channel counts, channel c at [c*CW +: CW]
//   out_valid           one-cycle pulse per emitted group
//   out_partial         emitted group had fewer than K beats
//   maj                 per-channel count >= THR, gated by out_valid
module ipv_group_reducer #(
   parameter int CH  = 4,
   parameter int K   = 4,
   parameter int LAT = 4,
   parameter int THR = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [CH-1:0]             ipv_in,
   input  logic                      flush,
   output logic [CH*$clog2(K+1)-1:0] vov,
   output logic                      out_valid,
   output logic                      out_partial,
   output logic [CH-1:0]             maj
);
   localparam int CW = $clog2(K + 1);
   localparam int BW = (K > 1) ? $clog2(K) : 1;
   localparam int VW = CH * CW;

   if (CH < 1 || CH > 16) begin : g_bad_ch
      $error("ipv_group_reducer: CH must be 1..16");
   end
   if (K < 1 || K > 255) begin : g_bad_k
      $error("ipv_group_reducer: K must be 1..255");
   end
   if (LAT < 1 || LAT > 16) begin : g_bad_lat
      $error("ipv_group_reducer: LAT must be 1..16");
   end
   if (THR < 0 || THR > K) begin : g_bad_thr
      $error("ipv_group_reducer: THR must be 0..K");
   end

   logic [BW-1:0] cnt;
   logic [VW-1:0] acc;
   logic [VW-1:0] sum;
   logic [CH-1:0] maj_d;
   logic          full;
   logic          emit;

   logic          st_v   [LAT];
   logic          st_p   [LAT];
   logic [VW-1:0] st_cnt [LAT];
   logic [CH-1:0] st_maj [LAT];

   // The incoming beat is folded in before the emit decision so the
   // closing beat of a group lands in the emitted counts.
   always_comb begin
      sum   = '0;
      maj_d = '0;
      for (int c = 0; c < CH; c++) begin
         sum[c*CW +: CW] = acc[c*CW +: CW]
                         + CW'(in_valid & ipv_in[c]);
         maj_d[c] = (sum[c*CW +: CW] >= CW'(THR));
      end
   end

   assign full = in_valid && (cnt == BW'(K - 1));
   assign emit = full || (flush && ((cnt != '0) || in_valid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
      end else if (emit) begin
         cnt <= '0;
         acc <= '0;
      end else if (in_valid) begin
         cnt <= cnt + BW'(1);
         acc <= sum;
      end
   end

   // Non-emitting cycles load zeros, so the output bus is clean
   // whenever out_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            st_v[i]   <= 1'b0;
            st_p[i]   <= 1'b0;
            st_cnt[i] <= '0;
            st_maj[i] <= '0;
         end
      end else begin
         st_v[0]   <= emit;
         st_p[0]   <= emit & ~full;
         st_cnt[0] <= emit ? sum : '0;
         st_maj[0] <= emit ? maj_d : '0;
         for (int i = 1; i < LAT; i++) begin
            st_v[i]   <= st_v[i-1];
            st_p[i]   <= st_p[i-1];
            st_cnt[i] <= st_cnt[i-1];
            st_maj[i] <= st_maj[i-1];
         end
      end
   end

   assign out_valid   = st_v[LAT-1];
   assign out_partial = st_p[LAT-1];
   assign vov         = st_cnt[LAT-1];
   assign maj         = st_maj[LAT-1];

endmodule
